// File: rtl/pipe_stall_ctrl.sv
// Hazard and stall sequencer for the five-stage pipeline: per-stage hold vector,
// ID/EX bubble and IF/ID flush, plus a stall-cycle counter and a sticky memory timeout.
module pipe_stall_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_rs1_ren,
    input  logic             id_rs2_ren,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd_addr,
    input  logic             ex_redirect,
    input  logic             ex_mc_busy,
    input  logic             mem_req,
    input  logic             mem_ack,
    input  logic             if_busy,
    output logic [4:0]       stall_ctrl,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             mem_timeout_err
);

    localparam int              TO_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {RUN, LU_STALL, MC_WAIT, MEM_WAIT} state_t;

    state_t          state, state_nxt;
    logic            lu;
    logic            mem_wait;
    logic [4:0]      hold;
    logic            bubble, flush;
    logic [TO_W-1:0] to_cnt, to_cnt_nxt;
    logic            err_nxt;

    assign lu = ex_is_load && (ex_rd_addr != 5'd0) &&
                ((id_rs1_ren && (id_rs1_addr == ex_rd_addr)) ||
                 (id_rs2_ren && (id_rs2_addr == ex_rd_addr)));

    // The ack cycle itself is never a memory stall, even while in MEM_WAIT.
    assign mem_wait = !mem_ack && ((state == MEM_WAIT) || mem_req);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        hold      = 5'b00000;
        bubble    = 1'b0;
        flush     = 1'b0;
        state_nxt = RUN;
        if (mem_wait) begin
            hold      = 5'b11111;
            state_nxt = MEM_WAIT;
        end else if (ex_mc_busy) begin
            hold      = 5'b11111;
            state_nxt = MC_WAIT;
        end else if (ex_redirect) begin
            bubble = 1'b1;
            flush  = 1'b1;
        end else if (lu && (state != LU_STALL)) begin
            hold      = 5'b00111;
            bubble    = 1'b1;
            state_nxt = LU_STALL;
        end else if (if_busy) begin
            hold   = 5'b00011;
            bubble = 1'b1;
        end
    end

    // Reset gates only the outputs, so no flop's data path depends on rst.
    assign stall_ctrl   = rst ? hold : 5'b11111;
    assign id_ex_bubble = rst && bubble;
    assign if_id_flush  = rst && flush;

    // The entry cycle is the first wait cycle: clear-and-count lands on 1.
    always_comb begin
        to_cnt_nxt = to_cnt;
        if (mem_wait) begin
            if (state != MEM_WAIT)
                to_cnt_nxt = TO_W'(1);
            else if (to_cnt != TO_MAX)
                to_cnt_nxt = to_cnt + 1'b1;
        end
        err_nxt = mem_timeout_err || (mem_wait && (to_cnt_nxt == TO_MAX));
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= RUN;
            to_cnt          <= '0;
            mem_timeout_err <= 1'b0;
            stall_cycles    <= '0;
        end else begin
            state           <= state_nxt;
            to_cnt          <= to_cnt_nxt;
            mem_timeout_err <= err_nxt;
            if ((hold != 5'b00000) && (stall_cycles != {CNT_W{1'b1}}))
                stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Central hazard and stall sequencer for the five-stage RV64 pipeline. Each cycle it produces the per-stage hold vector `stall_ctrl[4:0]` and the `id_ex_bubble` / `if_id_flush` controls consumed by the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It arbitrates between five stall and flush sources:
- data-memory wait
- multi-cycle ALU wait
- load-use hazard
- instruction-fetch wait
- EX-stage redirect

It also keeps a saturating stall-cycle counter and a sticky memory-timeout flag.

## Interface
Parameters:
- `CNT_W`, 32: width of the stall-cycle performance counter.
- `MEM_TIMEOUT`, 255: number of consecutive MEM_WAIT cycles that sets `mem_timeout_err`. Must be at least 1.

Ports:
- `clk`  in  1  pipeline clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `id_rs1_ren`, `id_rs2_ren`  in  1  the ID-stage instruction reads rs1 / rs2.
- `id_rs1_addr`, `id_rs2_addr`  in  5  ID-stage source register addresses.
- `ex_is_load`  in  1  EX stage holds a load.
- `ex_rd_addr`  in  5  EX-stage destination register.
- `ex_redirect`  in  1  taken branch or jump resolved in EX. Held high for every cycle the instruction sits in EX.
- `ex_mc_busy`  in  1  multi-cycle op (mul/div) in EX has not finished.
- `mem_req`  in  1  MEM stage has an outstanding data access.
- `mem_ack`  in  1  data access completes this cycle.
- `if_busy`  in  1  fetch for the current PC has not returned.
- `stall_ctrl`  out  5  hold vector, 1 = hold. Bit mapping:
  - [0] PC
  - [1] IF/ID
  - [2] ID/EX
  - [3] EX/MEM
  - [4] MEM/WB
- `id_ex_bubble`  out  1  ID/EX loads a NOP instead of the ID-stage values.
- `if_id_flush`  out  1  IF/ID loads a NOP.
- `stall_cycles`  out  `CNT_W`  saturating count of cycles with `stall_ctrl != 0`.
- `mem_timeout_err`  out  1  sticky flag; set once a memory wait reaches `MEM_TIMEOUT` cycles.

## Operation
- FSM states:
  - RUN (reset state)
  - LU_STALL
  - MC_WAIT
  - MEM_WAIT
- Outputs are combinational from the registered state and the current inputs.
- Load-use hazard `lu`: `ex_is_load && ex_rd_addr != 0 && ((id_rs1_ren && id_rs1_addr == ex_rd_addr) || (id_rs2_ren && id_rs2_addr == ex_rd_addr))`.
- Per-cycle priority, highest first:
  1. Memory wait: (state == MEM_WAIT, or `mem_req && !mem_ack`), and `mem_ack` is 0 this cycle.
     - `stall_ctrl` = 11111, bubble = 0, flush = 0.
     - `ex_redirect` is ignored; EX is frozen and re-asserts it later.
  2. Multi-cycle busy (`ex_mc_busy`): `stall_ctrl` = 11111; state goes to MC_WAIT.
  3. Redirect (`ex_redirect`):
     - `stall_ctrl` = 00000, `id_ex_bubble` = 1, `if_id_flush` = 1.
     - Overrides `lu` and `if_busy`.
  4. Load-use, only when state != LU_STALL:
     - `stall_ctrl` = 00111, `id_ex_bubble` = 1.
     - Next state is LU_STALL.
  5. Fetch wait (`if_busy`): `stall_ctrl` = 00011, `id_ex_bubble` = 1.
  6. Otherwise: all outputs 0.
- Transitions:
  - RUN → MEM_WAIT on `mem_req && !mem_ack`.
  - MEM_WAIT → RUN on the `mem_ack` cycle. That cycle is not stalled by memory; rules 2–6 apply to it.
  - RUN → LU_STALL on `lu` when no higher-priority rule fires.
  - LU_STALL → RUN after exactly one cycle, unless rule 1 or rule 2 fires.
  - MC_WAIT → RUN in the first cycle with `ex_mc_busy` = 0. That cycle is evaluated with rules 3–6.
- Timeout counter:
  - Cleared on entry to MEM_WAIT; increments each MEM_WAIT cycle.
  - When it reaches `MEM_TIMEOUT`, `mem_timeout_err` is set and stays set until reset.
  - The counter stops at `MEM_TIMEOUT`. The wait itself continues until `mem_ack`.
- `stall_cycles` increments each cycle with `stall_ctrl != 0` and saturates at all-ones.

## Timing
- While `rst` is low:
  - state = RUN, `stall_ctrl` = 11111, `id_ex_bubble` = 0, `if_id_flush` = 0.
  - `stall_cycles` = 0, `mem_timeout_err` = 0, timeout counter = 0.
- Reset is asynchronous on assertion. Released on the first `clk` edge with `rst` high. Reset mid-wait abandons the wait with no residual state.
- Zero-cycle latency from inputs to `stall_ctrl` / bubble / flush: they must settle within the same cycle, before the register edge.
- A load-use hazard costs exactly 1 stall cycle. A redirect costs 0 stall cycles plus 2 flushed slots.
- `mem_req` with `mem_ack` in the same cycle: no stall, and no MEM_WAIT entry.
- `stall_cycles` and `mem_timeout_err` are registered; they update one cycle after the qualifying condition.

## Test plan
- Load-use: EX holds a load with `ex_rd_addr` = 5 while ID reads rs1 = 5 → one cycle of `stall_ctrl` = 00111 with bubble = 1; next cycle all 0; `stall_cycles` = 1.
- `ex_rd_addr` = 0 load with rs1 = 0 → no stall. Same with rs2 match but `id_rs2_ren` = 0 → no stall.
- Memory wait: `mem_req` = 1 with `mem_ack` low for 3 cycles, then high → 3 cycles of 11111, ack cycle 00000. With `ex_redirect` = 1 throughout, flush appears only on the ack cycle.
- Timeout: `MEM_TIMEOUT` = 4, `mem_ack` held low for 6 cycles → `mem_timeout_err` rises after the 4th wait cycle, stays high after ack, clears only on reset.
- Simultaneous events: `ex_redirect`, `lu` and `if_busy` all asserted → 00000, bubble = 1, flush = 1. `ex_mc_busy` for 2 cycles together with `lu` → 11111 twice, then 00111 once.
- Reset: assert `rst` low mid-MEM_WAIT → outputs immediately take reset values. After release with idle inputs, the first cycle gives 00000.
